// File: rtl/frq_divider_multi.sv
// N-channel half-period-ROM clock divider with glitch-free select changes and shared phase sync.
module frq_divider_multi #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned CNT_W    = 24,
    parameter string       ROM_FILE = ""
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_CH*SEL_W-1:0]   F_select,
    input  logic [N_CH-1:0]         en,
    input  logic                    sync,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         pending
);

    localparam int unsigned ROM_DEPTH = 2 ** SEL_W;

    // Built-in half-period table: entry k holds k (code 0 = stopped).
    function automatic logic [CNT_W-1:0] rom_half(input logic [SEL_W-1:0] code);
        return CNT_W'(code);
    endfunction

    // Only the built-in table exists in this block; reject an external image at elaboration.
    if (ROM_FILE != "") begin : g_rom_file_check
        $error("frq_divider_multi: external ROM image not available, depth %0d", ROM_DEPTH);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SEL_W-1:0] sel_req;
        logic [SEL_W-1:0] sel_act;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half;
        logic             out_q;
        logic             tick_q;
        logic             idle;

        assign sel_req = F_select[i*SEL_W +: SEL_W];
        assign half    = rom_half(sel_act);
        assign idle    = !en[i] || (half == '0);

        // Per-channel divider: sync, then idle, then terminal count, then count.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sel_act <= '0;
                cnt     <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else if (sync || idle) begin
                cnt     <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                sel_act <= en[i] ? sel_req : '0;
            end else if (cnt == half - CNT_W'(1)) begin
                cnt    <= '0;
                out_q  <= ~out_q;
                tick_q <= ~out_q;
                // Falling edge closes the period; only here may the code change.
                if (out_q) begin
                    sel_act <= sel_req;
                end
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick_q <= 1'b0;
            end
        end

        assign clk_out[i] = out_q;
        assign tick[i]    = tick_q;
        assign pending[i] = en[i] && (sel_req != sel_act);
    end

endmodule

// File: tb/tb_frq_divider_multi.sv
// Scoreboard bench for frq_divider_multi: a period/phase model predicts outputs per edge.
module tb_frq_divider_multi;

    localparam int N_CH  = 2;
    localparam int SEL_W = 5;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [N_CH*SEL_W-1:0] F_select;
    logic [N_CH-1:0]       en;
    logic                  sync;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       pending;

    frq_divider_multi #(.N_CH(N_CH), .SEL_W(SEL_W), .CNT_W(24), .ROM_FILE("")) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .F_select (F_select),
        .en       (en),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH-1:0] clk_out;
        logic [N_CH-1:0] tick;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per channel the active code and position within the current 2k-cycle period.
    int  m_act[N_CH];
    int  m_pos[N_CH];
    bit  m_valid = 1'b0;

    int  edge_cnt;
    int  rise_edge;
    int  hi_len;
    int  min_hi;
    logic prev0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sel_of(input int ch);
        logic [N_CH*SEL_W-1:0] v;
        v = F_select;
        return int'(v[ch*SEL_W +: SEL_W]);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic exp_t model_edge();
        exp_t e;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!reset_n) begin
                m_act[ch] = 0;
                m_pos[ch] = 0;
            end else if (sync || !en[ch] || m_act[ch] == 0) begin
                m_act[ch] = en[ch] ? sel_of(ch) : 0;
                m_pos[ch] = 0;
            end else begin
                m_pos[ch]++;
                if (m_pos[ch] == 2 * m_act[ch]) begin
                    m_pos[ch] = 0;
                    m_act[ch] = sel_of(ch);
                end
            end
            e.clk_out[ch] = (m_act[ch] != 0) && (m_pos[ch] >= m_act[ch]);
            e.tick[ch]    = e.clk_out[ch] && (m_pos[ch] == m_act[ch]);
        end
        return e;
    endfunction

    function automatic logic [N_CH-1:0] model_pending();
        logic [N_CH-1:0] p;
        for (int ch = 0; ch < N_CH; ch++)
            p[ch] = en[ch] && (sel_of(ch) != m_act[ch]);
        return p;
    endfunction

    // One cycle: check pending, push expectation, clock, pop and compare, track ch0 shape.
    task automatic cyc(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            #1;
            if (m_valid) check("pending", 32'(pending), 32'(model_pending()));
            if (!reset_n) m_valid = 1'b1;
            exp_q.push_back(model_edge());
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check("clk_out", 32'(clk_out), 32'(e.clk_out));
            check("tick", 32'(tick), 32'(e.tick));
            if (!reset_n) edge_cnt = 0;
            else          edge_cnt++;
            if (clk_out[0] && !prev0 && rise_edge < 0) rise_edge = edge_cnt;
            if (clk_out[0]) hi_len++;
            else begin
                if (prev0 && hi_len < min_hi) min_hi = hi_len;
                hi_len = 0;
            end
            prev0 = clk_out[0];
        end
    endtask

    task automatic wait_rise(input string tag);
        int budget;
        budget = 100;
        while (!tick[0] && budget > 0) begin
            cyc(1);
            budget--;
        end
        if (budget == 0) check(tag, 32'(tick[0]), 32'd1);
    endtask

    task automatic set_sel(input int s0, input int s1);
        F_select = {SEL_W'(s1), SEL_W'(s0)};
    endtask

    initial begin
        reset_n = 1'b0; en = 2'b01; sync = 1'b0; set_sel(3, 0);
        edge_cnt = 0; rise_edge = -1; hi_len = 0; min_hi = 1000; prev0 = 1'b0;
        @(posedge clk); #1;

        // Reset held with a live select: outputs stay low.
        cyc(2);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);

        // Release: load at edge 1, first rise at edge 4, period 6.
        reset_n = 1'b1;
        cyc(20);
        check("s1_first_rise", 32'(rise_edge), 32'd4);

        // Select change just after a rise: high phase completes, no runt.
        wait_rise("s2_wait");
        cyc(1);
        set_sel(5, 0);
        min_hi = 1000;
        cyc(1);
        check("s2_pending", 32'(pending[0]), 32'd1);
        cyc(30);
        check("s2_no_runt", 32'(min_hi >= 3), 32'd1);

        // Fastest code, then stop at a period end.
        set_sel(1, 0);
        cyc(16);
        set_sel(0, 0);
        cyc(10);
        check("s3_held_low", 32'(clk_out[0]), 32'd0);
        check("s3_no_pending", 32'(pending[0]), 32'd0);

        // Two channels phase-aligned by a one-cycle sync pulse.
        en = 2'b11; set_sel(2, 4);
        cyc(7);
        sync = 1'b1; cyc(1);
        check("s4_sync_low", 32'(clk_out), 32'd0);
        sync = 1'b0; cyc(24);

        // Abrupt disable mid-high, then re-enable with code 3.
        set_sel(3, 4);
        wait_rise("s5_wait");
        en = 2'b10; cyc(1);
        check("s5_forced_low", 32'(clk_out[0]), 32'd0);
        cyc(2);
        en = 2'b11; cyc(14);

        // Reset mid-high-phase, then restart as after power-up.
        wait_rise("s6_wait");
        reset_n = 1'b0; cyc(1);
        check("s6_rst_low", 32'(clk_out), 32'd0);
        cyc(1);
        reset_n = 1'b1; rise_edge = -1; prev0 = 1'b0; set_sel(3, 0); en = 2'b01;
        cyc(12);
        check("s6_first_rise", 32'(rise_edge), 32'd4);

        // Random soak over small codes with occasional sync.
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 9) == 0) set_sel($urandom_range(0, 6), $urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) en = 2'($urandom_range(0, 3));
            sync = ($urandom_range(0, 49) == 0);
            cyc(1);
        end
        sync = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
